// File: rtl/overlay_pkg.sv
// Shared types, widths, colours and font glyph data for the text overlay mux.
package overlay_pkg;

  localparam int RGB_W       = 12;
  localparam int FONT_ADDR_W = 11;

  localparam logic [RGB_W-1:0] BLACK = 12'h000;
  localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } blink_state_e;

  // Glyph rows indexed by {char[6:0], row[3:0]}; bit 7 is the leftmost column.
  function automatic logic [7:0] font_row(input logic [FONT_ADDR_W-1:0] addr);
    logic [7:0] row;
    row = 8'h00;
    case (addr[10:4])
      7'h46: begin
        case (addr[3:0])
          4'h2:                row = 8'hFE;
          4'h3:                row = 8'h66;
          4'h4:                row = 8'h62;
          4'h5:                row = 8'h68;
          4'h6:                row = 8'h78;
          4'h7:                row = 8'h68;
          4'h8, 4'h9, 4'hA:    row = 8'h60;
          4'hB:                row = 8'hF0;
          default:             row = 8'h00;
        endcase
      end
      7'h7F: begin
        if (addr[3:0] >= 4'h2 && addr[3:0] <= 4'hD) row = 8'hFF;
      end
      default: row = 8'h00;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/font_rom.sv
// 2048 x 8 font ROM with a registered one-cycle read; contents are not reset.
module font_rom
  import overlay_pkg::*;
(
  input  logic                   clk,
  input  logic [FONT_ADDR_W-1:0] addr,
  output logic [7:0]             data
);

  always_ff @(posedge clk) begin
    data <= font_row(addr);
  end

endmodule

// File: rtl/text_overlay_mux.sv
// Two-stage pixel pipeline that overlays blinking font text on background video.
//   state | meaning
//   OFF   | overlay hidden, waiting for overlay_en at a frame tick
//   SHOW  | text drawn, counting frames toward the blank phase
//   BLANK | text hidden for the blink off-phase, counting frames toward SHOW
module text_overlay_mux
  import overlay_pkg::*;
#(
  parameter logic [RGB_W-1:0] TEXT_RGB     = WHITE,
  parameter int               BLINK_FRAMES = 30,
  parameter bit               BLINK_EN     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   video_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   frame_tick,
  input  logic                   overlay_en,
  input  logic                   text_on,
  input  logic [2:0]             bit_addr,
  input  logic [FONT_ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]       bg_rgb,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [RGB_W-1:0]       rgb_out
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  blink_state_e     state;
  logic [7:0]       frame_cnt;
  logic [7:0]       row_data;
  logic             video_on_d1;
  logic             hsync_d1;
  logic             vsync_d1;
  logic             text_on_d1;
  logic [2:0]       bit_addr_d1;
  logic [RGB_W-1:0] bg_rgb_d1;
  logic             glyph_bit;

  font_rom u_font_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (row_data)
  );

  // Overlay enable is only sampled at frame ticks so a frame is never torn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      frame_cnt <= '0;
    end else if (frame_tick) begin
      case (state)
        OFF: begin
          if (overlay_en) begin
            state     <= SHOW;
            frame_cnt <= '0;
          end
        end
        SHOW: begin
          if (!overlay_en) begin
            state     <= OFF;
            frame_cnt <= '0;
          end else if (!BLINK_EN) begin
            frame_cnt <= '0;
          end else if (frame_cnt == LAST_FRAME) begin
            state     <= BLANK;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        BLANK: begin
          if (!overlay_en) begin
            state     <= OFF;
            frame_cnt <= '0;
          end else if (frame_cnt == LAST_FRAME) begin
            state     <= SHOW;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state     <= OFF;
          frame_cnt <= '0;
        end
      endcase
    end
  end

  // Syncs reset to their inactive (high) level so post-reset outputs look idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      video_on_d1 <= 1'b0;
      hsync_d1    <= 1'b1;
      vsync_d1    <= 1'b1;
      text_on_d1  <= 1'b0;
      bit_addr_d1 <= '0;
      bg_rgb_d1   <= BLACK;
    end else begin
      video_on_d1 <= video_on;
      hsync_d1    <= hsync_in;
      vsync_d1    <= vsync_in;
      text_on_d1  <= text_on;
      bit_addr_d1 <= bit_addr;
      bg_rgb_d1   <= bg_rgb;
    end
  end

  assign glyph_bit = row_data[3'd7 - bit_addr_d1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      rgb_out   <= BLACK;
    end else begin
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
      if (!video_on_d1)
        rgb_out <= BLACK;
      else if (text_on_d1 && glyph_bit && state == SHOW)
        rgb_out <= TEXT_RGB;
      else
        rgb_out <= bg_rgb_d1;
    end
  end

endmodule

// File: tb/tb_text_overlay_mux.sv
// Scoreboard bench: a blinking instance (3 frames) and a steady instance share stimulus.
`timescale 1ns/1ps
module tb_text_overlay_mux;

  typedef struct {
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic        hs;
    logic        vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, video_on, hsync_in, vsync_in, frame_tick, overlay_en, text_on;
  logic [2:0]  bit_addr;
  logic [10:0] rom_addr;
  logic [11:0] bg_rgb;
  logic        hs_a, vs_a, hs_b, vs_b;
  logic [11:0] rgb_a, rgb_b;
  logic [27:0] obs_vec;

  int checks = 0;
  int failures = 0;
  int st_a = 0, cnt_a = 0, st_b = 0, cnt_b = 0;  // 0 = OFF, 1 = SHOW, 2 = BLANK
  exp_t sb[$];
  exp_t e;
  exp_t rst_exp = '{rgb_a: 12'h000, rgb_b: 12'h000, hs: 1'b1, vs: 1'b1};

  logic [7:0] f_rows [16] = '{8'h00, 8'h00, 8'hFE, 8'h66, 8'h62, 8'h68, 8'h78, 8'h68,
                              8'h60, 8'h60, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  text_overlay_mux #(.TEXT_RGB(12'hFFF), .BLINK_FRAMES(3), .BLINK_EN(1'b1)) u_blink (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .overlay_en(overlay_en), .text_on(text_on), .bit_addr(bit_addr),
    .rom_addr(rom_addr), .bg_rgb(bg_rgb), .hsync_out(hs_a), .vsync_out(vs_a), .rgb_out(rgb_a));

  text_overlay_mux #(.TEXT_RGB(12'hFFF), .BLINK_FRAMES(30), .BLINK_EN(1'b0)) u_steady (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .overlay_en(overlay_en), .text_on(text_on), .bit_addr(bit_addr),
    .rom_addr(rom_addr), .bg_rgb(bg_rgb), .hsync_out(hs_b), .vsync_out(vs_b), .rgb_out(rgb_b));

  assign obs_vec = {rgb_a, rgb_b, hs_a, vs_a, hs_b, vs_b};

  function automatic logic [27:0] pack(input exp_t x);
    return {x.rgb_a, x.rgb_b, x.hs, x.vs, x.hs, x.vs};
  endfunction

  function automatic logic [7:0] ref_glyph(input logic [10:0] ra);
    if (ra[10:4] == 7'h46) return f_rows[ra[3:0]];
    if (ra[10:4] == 7'h7F && ra[3:0] >= 4'h2 && ra[3:0] <= 4'hD) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic model_next(inout int st, inout int cnt, input logic tick, input logic en,
                            input int bf, input bit ben);
    if (!tick) return;
    if (st == 0) begin
      if (en) begin st = 1; cnt = 0; end
    end else if (!en) begin
      st = 0; cnt = 0;
    end else if (st == 1 && !ben) begin
      cnt = 0;
    end else if (cnt == bf - 1) begin
      st = (st == 1) ? 2 : 1; cnt = 0;
    end else begin
      cnt = cnt + 1;
    end
  endtask

  task automatic step(input logic rst, input logic vid, input logic hs, input logic vs,
                      input logic tick, input logic en, input logic ton, input logic [2:0] ba,
                      input logic [10:0] ra, input logic [11:0] bg, output exp_t eo);
    exp_t n;
    logic [7:0] g;
    logic gbit;
    rst_n = rst; video_on = vid; hsync_in = hs; vsync_in = vs; frame_tick = tick;
    overlay_en = en; text_on = ton; bit_addr = ba; rom_addr = ra; bg_rgb = bg;
    if (!rst) begin
      st_a = 0; cnt_a = 0; st_b = 0; cnt_b = 0;
      n = rst_exp;
      if (sb.size() > 0) sb[sb.size()-1] = rst_exp;
    end else begin
      model_next(st_a, cnt_a, tick, en, 3, 1'b1);
      model_next(st_b, cnt_b, tick, en, 30, 1'b0);
      g = ref_glyph(ra);
      gbit = g[3'd7 - ba];
      n.hs = hs;
      n.vs = vs;
      n.rgb_a = !vid ? 12'h000 : (ton && gbit && st_a == 1) ? 12'hFFF : bg;
      n.rgb_b = !vid ? 12'h000 : (ton && gbit && st_b == 1) ? 12'hFFF : bg;
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
    eo = sb.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, {7'h46, 4'h5}, 12'h0F0, e);
      checks++;
      if (rgb_a !== 12'h000 || hs_a !== 1'b1 || vs_a !== 1'b1) begin
        failures++;
        $display("FAIL reset_state rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1", rgb_a, hs_a, vs_a);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, {7'h46, 4'h5}, 12'h0F0, e);
      checks++;
      if (obs_vec !== pack(e)) begin
        failures++;
        $display("FAIL reset_release got=%h want=%h", obs_vec, pack(e));
      end
    end
  endtask

  task automatic test_text();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // enter SHOW
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, {7'h46, 4'h5}, 12'h00F, e);  // lit
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, {7'h46, 4'h5}, 12'h00F, e);  // unlit
    checks++;
    if (rgb_a !== 12'hFFF || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL text_lit got=%h want=fff", rgb_a);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, {7'h46, 4'h5}, 12'h00F, e);  // blanking
    checks++;
    if (rgb_a !== 12'h00F || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL text_unlit got=%h want=00f", rgb_a);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, {7'h46, 4'h5}, 12'h00F, e);  // hsync
    checks++;
    if (rgb_a !== 12'h000 || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL video_off got=%h want=000", rgb_a);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 11'd0, 12'h00F, e);
    checks++;
    if (hs_a !== 1'b0 || rgb_a !== 12'hFFF || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL hsync_delay hs=%b rgb=%h want hs=0 rgb=fff", hs_a, rgb_a);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 11'd0, 12'h00F, e);
    checks++;
    if (hs_a !== 1'b1 || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL hsync_release hs=%b want 1", hs_a);
    end
  endtask

  // Blinking instance enters this test in SHOW with its counter at 0.
  task automatic test_blink();
    logic [11:0] want;
    for (int f = 0; f < 8; f++) begin
      for (int px = 0; px < 8; px++) begin
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'(px), {7'h7F, 4'h4}, 12'h123, e);
        checks++;
        if (obs_vec !== pack(e)) begin
          failures++;
          $display("FAIL blink_sb frame=%0d got=%h want=%h", f, obs_vec, pack(e));
        end
        if (px == 1) begin
          want = ((f / 3) % 2 == 0) ? 12'hFFF : 12'h123;
          checks++;
          if (rgb_a !== want) begin
            failures++;
            $display("FAIL blink_phase frame=%0d got=%h want=%h", f, rgb_a, want);
          end
        end
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);
      checks++;
      if (obs_vec !== pack(e)) begin
        failures++;
        $display("FAIL blink_tick got=%h want=%h", obs_vec, pack(e));
      end
    end
  endtask

  task automatic test_steady();
    for (int f = 0; f < 100; f++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, {7'h46, 4'h2}, 12'h0A0, e);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);
      checks++;
      if (rgb_b !== 12'hFFF || obs_vec !== pack(e)) begin
        failures++;
        $display("FAIL steady frame=%0d got=%h want=%h", f, obs_vec, pack(e));
      end
    end
  endtask

  task automatic test_overlay_drop();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 11'd0, 12'h000, e);  // force OFF
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // SHOW, cnt 0
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, {7'h7F, 4'h6}, 12'h456, e);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, {7'h7F, 4'h6}, 12'h456, e);
    checks++;
    if (rgb_a !== 12'hFFF || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL drop_midframe got=%h want=fff", rgb_a);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 11'd0, 12'h000, e);  // tick -> OFF
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, {7'h7F, 4'h6}, 12'h456, e);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // SHOW, cnt 0
    checks++;
    if (rgb_a !== 12'h456 || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL drop_off got=%h want=456", rgb_a);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // cnt 1
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // cnt 2
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 11'd0, 12'h000, e);  // wrap + drop
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);  // OFF->SHOW only
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, {7'h7F, 4'h6}, 12'h456, e);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 11'd0, 12'h456, e);
    checks++;
    if (rgb_a !== 12'hFFF || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL drop_at_wrap got=%h want=fff", rgb_a);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd0, 12'h000, e);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, {7'h7F, 4'h3}, 12'h789, e);
    for (int i = 0; i < 2; i++) begin
      step((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0,
           {7'h7F, 4'h3}, 12'h789, e);
      checks++;
      if (rgb_a !== 12'h000 || hs_a !== 1'b1 || vs_a !== 1'b1 || obs_vec !== pack(e)) begin
        failures++;
        $display("FAIL reset_mid out=%0d rgb=%h hs=%b vs=%b want 000/1/1", i, rgb_a, hs_a, vs_a);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, {7'h7F, 4'h3}, 12'h789, e);
    checks++;
    if (rgb_a !== 12'h789 || hs_a !== 1'b0 || obs_vec !== pack(e)) begin
      failures++;
      $display("FAIL reset_mid_off rgb=%h hs=%b want 789/0", rgb_a, hs_a);
    end
  endtask

  task automatic test_back_to_back();
    logic en;
    logic [10:0] ra;
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      case ($urandom_range(0, 2))
        0:       ra = {7'h46, 4'($urandom_range(0, 15))};
        1:       ra = {7'h7F, 4'($urandom_range(0, 15))};
        default: ra = 11'($urandom);
      endcase
      step(1'b1, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) != 0),
           1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0), en,
           1'($urandom_range(0, 3) != 0), 3'($urandom), ra, 12'($urandom), e);
      checks++;
      if (obs_vec !== pack(e)) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs_vec, pack(e));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; frame_tick = 1'b0;
    overlay_en = 1'b0; text_on = 1'b0; bit_addr = '0; rom_addr = '0; bg_rgb = '0;
    sb.push_back(rst_exp);
    #2;
    test_reset();
    test_text();
    test_blink();
    test_steady();
    test_overlay_drop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_overlay_mux.md
TEXT_OVERLAY_MUX -- requirements
Module: text_overlay_mux

Interface
REQ-001 SHALL have parameter TEXT_RGB, default 12'hFFF, colour of lit glyph pixels.
REQ-002 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period, legal range 1..255.
REQ-003 SHALL have parameter BLINK_EN, default 1, 1 = blink, 0 = steady text.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  pixel clock, all logic rising-edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 video_on  in  1  active display area for the current pixel.
REQ-008 hsync_in / vsync_in  in  1 each  raw syncs from the timing generator, aligned with pix_x/pix_y.
REQ-009 frame_tick  in  1  one-cycle pulse at frame start (vblank).
REQ-010 overlay_en  in  1  level request to show the overlay, same signal that enables the text-address stage.
REQ-011 text_on  in  1  current pixel lies inside a text cell.
REQ-012 bit_addr  in  3  glyph column within the font row.
REQ-013 rom_addr  in  11  font ROM address {char[6:0], row[3:0]}.
REQ-014 bg_rgb  in  12  background colour for the current pixel.
REQ-015 hsync_out / vsync_out  out  1 each  syncs delayed to match rgb_out.
REQ-016 rgb_out  out  12  final pixel colour.

Function
REQ-017 Fixed latency of 2 clocks from every input pixel (video_on, syncs, text_on, bit_addr, rom_addr, bg_rgb) to rgb_out / hsync_out / vsync_out.
REQ-018 Stage 1: font ROM registered read of rom_addr; bit_addr, text_on, video_on, syncs and bg_rgb registered alongside.
REQ-019 Stage 2: glyph bit = row_data[7 - bit_addr_d1] (bit 7 = leftmost column); output register.
REQ-020 rgb_out = 0 when video_on_d2 = 0; else TEXT_RGB when text_on_d2 & glyph bit & visible; else bg_rgb_d2.
REQ-021 Blink FSM states OFF, SHOW, BLANK; 8-bit frame counter; all state/counter updates only on cycles with frame_tick = 1.
REQ-022 OFF -> SHOW on frame_tick with overlay_en = 1; counter cleared.
REQ-023 SHOW: counter increments per frame_tick; at counter = BLINK_FRAMES-1 goes to BLANK with counter cleared, only if BLINK_EN = 1; with BLINK_EN = 0 counter holds 0 and state stays SHOW.
REQ-024 BLANK: counter increments per frame_tick; at counter = BLINK_FRAMES-1 goes to SHOW with counter cleared.
REQ-025 SHOW or BLANK -> OFF on frame_tick with overlay_en = 0; takes priority over the counter wrap on the same cycle.
REQ-026 overlay_en changes between frame_ticks have no effect until the next frame_tick (tear-free).
REQ-027 visible = (state == SHOW); evaluated at stage 2.
REQ-028 BLINK_FRAMES = 1 toggles SHOW/BLANK every frame.

Reset
REQ-029 rst_n = 0 on a clk edge: state = OFF, counter = 0, all pipeline registers 0, rgb_out = 0, hsync_out = vsync_out = 1 (inactive).
REQ-030 Reset mid-frame or mid-blink: takes effect next edge; first two post-reset outputs come from reset-valued pipeline, never TEXT_RGB.
REQ-031 Font ROM contents are not reset; text_on_d pipeline = 0 masks stale row_data.

Structure
REQ-032 Package overlay_pkg: state enum (OFF, SHOW, BLANK), RGB_W = 12, FONT_ADDR_W = 11, colour constants (BLACK, WHITE).
REQ-033 One sub-module font_rom: 2048 x 8, synchronous 1-cycle read, initialised from the team font file.
REQ-034 Target size 120-400 lines of RTL including font_rom wrapper, excluding font data.

Verification
REQ-035 Reset then overlay_en = 1, frame_tick once -> state SHOW; pixel with text_on = 1, rom_addr = {7'h46, 4'h5}, lit bit selected -> rgb_out = 12'hFFF exactly 2 clocks later.
REQ-036 Same pixel, glyph bit 0, bg_rgb = 12'h00F -> rgb_out = 12'h00F; video_on = 0 -> rgb_out = 0; hsync_in pulse appears on hsync_out 2 clocks later.
REQ-037 BLINK_FRAMES = 3: 3 frame_ticks -> BLANK (text pixels show bg); 3 more -> SHOW.
REQ-038 BLINK_EN = 0: 100 frame_ticks -> state stays SHOW, text always lit.
REQ-039 overlay_en dropped mid-frame -> text still lit until next frame_tick, then OFF; drop coinciding with counter wrap -> OFF, not BLANK.
REQ-040 rst_n low for 1 clock during SHOW with text pixels streaming -> next 2 outputs rgb_out = 0, syncs = 1, state OFF.
